sign_narrow: RTL
================

SIGN_NARROW -- requirements
Module: sign_narrow

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the target signed field width; legal range 2..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  an input beat is offered.
REQ-005 SHALL have port in_ready  output  1  the block can accept a beat this cycle.
REQ-006 SHALL have port in_data  input  16  16-bit two's-complement value to narrow.
REQ-007 SHALL have port sat_en  input  1  sampled with the beat; 1 = saturate on overflow, 0 = wrap (truncate).
REQ-008 SHALL have port out_valid  output  1  out_data/out_ovf hold a valid result.
REQ-009 SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  narrowed result.
REQ-011 SHALL have port out_ovf  output  1  the value of this result did not fit in WIDTH signed bits.
REQ-012 SHALL have port ovf_sticky  output  1  at least one overflow since the last reset or clear.
REQ-013 SHALL have port ovf_count  output  8  number of accepted overflowing beats, saturating.
REQ-014 SHALL have port clr_count  input  1  synchronous clear of ovf_count and ovf_sticky.

Function
REQ-015 SHALL accept a beat on a rising edge when in_valid and in_ready are both 1.
REQ-016 SHALL drive in_ready = !out_valid || out_ready, combinationally; no other dependency.
REQ-017 SHALL classify a value as fitting iff in_data[15:WIDTH-1] are all equal.
REQ-018 SHALL, for a fitting value, produce out_data = in_data[WIDTH-1:0] and out_ovf = 0, independent of sat_en.
REQ-019 SHALL, for a non-fitting value with sat_en=1, produce out_data = the most negative WIDTH-bit value if in_data[15]=1, else the most positive, with out_ovf = 1.
REQ-020 SHALL, for a non-fitting value with sat_en=0, produce out_data = in_data[WIDTH-1:0] with out_ovf = 1.
REQ-021 SHALL register the result: a beat accepted at edge k appears with out_valid=1 immediately after edge k; latency is 1 cycle.
REQ-022 SHALL hold out_data and out_ovf stable and keep out_valid=1 while out_valid=1 and out_ready=0.
REQ-023 SHALL, on an edge with the output drained and a new beat accepted in the same cycle, load the new result with no bubble; full throughput of one beat per cycle.
REQ-024 SHALL clear out_valid on an edge where out_ready=1 and no beat is accepted.
REQ-025 SHALL increment ovf_count on each accepted overflowing beat, saturating at 255 (no wrap).
REQ-026 SHALL set ovf_sticky on any accepted overflowing beat.
REQ-027 SHALL, when clr_count=1, set ovf_count=0 and ovf_sticky=0 on that edge; the clear wins over a simultaneous overflow, and that beat is not counted.
REQ-028 SHALL leave out_data and out_ovf unaffected by clr_count.

Reset
REQ-029 SHALL, while rst=1 and independent of clk, force out_valid=0, out_data=0, out_ovf=0, ovf_sticky=0, ovf_count=0.
REQ-030 SHALL drop any held result when reset is asserted mid-transfer; no beat is accepted while rst=1.
REQ-031 SHALL drive in_ready=1 from the first cycle after rst deasserts.

Verification (WIDTH=8)
REQ-032 SHALL cover the fitting boundaries: 0x007F -> 0x7F, ovf 0; 0xFF80 -> 0x80, ovf 0; 0x0000 -> 0x00; 0xFFFF -> 0xFF, ovf 0, each one cycle after accept.
REQ-033 SHALL cover overflow: 0x0080 sat_en=1 -> 0x7F, ovf 1; sat_en=0 -> 0x80, ovf 1; 0xFE00 sat_en=1 -> 0x80; 0x7FFF sat_en=0 -> 0xFF; ovf_sticky=1.
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and the output holds; then out_ready=1 continuously with back-to-back inputs -> one result per cycle, in order, none lost or duplicated.
REQ-035 SHALL cover the counter: 300 overflowing beats -> ovf_count=255; then clr_count=1 coincident with an overflowing beat -> ovf_count=0 and ovf_sticky=0.
REQ-036 SHALL cover reset: rst asserted asynchronously while out_valid=1 and out_ready=0 -> all outputs 0 immediately; after release, 0x0001 -> 0x01 delivered normally.

Source files
------------

// File: rtl/sign_narrow_if.sv
// Valid/ready stream bundle for sign_narrow: 16-bit signed beat in, WIDTH-bit
// narrowed result plus overflow flag out.
interface sign_narrow_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, sat_en, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, sat_en, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/sign_narrow.sv
// Narrows a 16-bit two's-complement stream to WIDTH signed bits with optional
// saturation; one-deep registered output stage plus overflow statistics.
module sign_narrow_core #(
  parameter int WIDTH = 8
) (
  input  logic [15:0]      din,
  input  logic             sat_en,
  output logic [WIDTH-1:0] dout,
  output logic             ovf
);
  localparam int HI_W = 17 - WIDTH;

  // Value fits when every bit from the target sign bit upward is a copy of it.
  logic [HI_W-1:0]  hi;
  logic             fits;
  logic [WIDTH-1:0] max_pos;
  logic [WIDTH-1:0] max_neg;

  assign hi      = din[15:WIDTH-1];
  assign fits    = (&hi) | ~(|hi);
  assign max_pos = {1'b0, {(WIDTH-1){1'b1}}};
  assign max_neg = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    dout = din[WIDTH-1:0];
    ovf  = ~fits;
    if (!fits && sat_en)
      dout = din[15] ? max_neg : max_pos;
  end
endmodule

module sign_narrow #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  sign_narrow_if.slave bus,
  input  logic       clr_count,
  output logic       ovf_sticky,
  output logic [7:0] ovf_count
);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             ovf;
  } res_t;

  res_t res_nxt;
  res_t res_q;
  logic out_vld;
  logic accept;

  sign_narrow_core #(.WIDTH(WIDTH)) u_core (
    .din    (bus.in_data),
    .sat_en (bus.sat_en),
    .dout   (res_nxt.data),
    .ovf    (res_nxt.ovf)
  );

  // Skid-free single stage: refill in the same cycle the consumer drains it.
  assign bus.in_ready  = !out_vld || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = res_q.data;
  assign bus.out_ovf   = res_q.ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      res_q   <= '0;
    end else if (accept) begin
      out_vld <= 1'b1;
      res_q   <= res_nxt;
    end else if (bus.out_ready) begin
      out_vld <= 1'b0;
    end
  end

  // Clear takes priority over a coincident overflowing beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= 8'd0;
    end else if (clr_count) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= 8'd0;
    end else if (accept && res_nxt.ovf) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != 8'hFF)
        ovf_count <= ovf_count + 8'd1;
    end
  end
endmodule
